// File: rtl/uart_rx_cmd_ctrl.sv
// Sequences UART receiver bytes into 5-byte register-access frames (sync, cmd, addr, data, checksum).
// Valid frames issue a one-cycle write/read strobe; malformed, parity-corrupted or stalled frames are counted.
module uart_rx_cmd_ctrl #(
    parameter int unsigned TIMEOUT_CLKS = 1000,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    input  logic       i_Rx_Error,
    output logic       o_Wr_En,
    output logic       o_Rd_En,
    output logic [7:0] o_Addr,
    output logic [7:0] o_Wr_Data,
    output logic       o_Busy,
    output logic       o_Frame_Err,
    output logic [7:0] o_Err_Count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_CHK
    } state_e;

    localparam logic [15:0] TIMEOUT_VAL = TIMEOUT_CLKS[15:0];
    localparam logic [7:0]  CMD_WR      = 8'h01;
    localparam logic [7:0]  CMD_RD      = 8'h02;

    state_e      state_q, state_d;
    logic        dv_q;
    logic [15:0] timer_q, timer_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        wr_en_q, wr_en_d;
    logic        rd_en_q, rd_en_d;
    logic        ferr_q, ferr_d;
    logic [7:0]  out_addr_q, out_addr_d;
    logic [7:0]  out_wdata_q, out_wdata_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic accept;
    logic timeout;
    logic drop;

    // Only the rising edge of the DV level counts, so long DV pulses yield one byte.
    assign accept  = i_Rx_DV & ~dv_q;
    assign timeout = (state_q != S_IDLE) && (timer_q == TIMEOUT_VAL);

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q + 16'd1;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        data_d      = data_q;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        ferr_d      = 1'b0;
        out_addr_d  = out_addr_q;
        out_wdata_d = out_wdata_q;
        err_cnt_d   = err_cnt_q;
        drop        = 1'b0;

        if (state_q == S_IDLE) begin
            timer_d = '0;
        end

        // A byte arriving on the expiry cycle takes priority over the timeout.
        if (accept) begin
            timer_d = '0;
            case (state_q)
                S_IDLE: begin
                    if ((i_Rx_Byte == SYNC_BYTE) && !i_Rx_Error) begin
                        state_d = S_CMD;
                    end
                end
                S_CMD: begin
                    if (i_Rx_Error) begin
                        drop = 1'b1;
                    end else begin
                        cmd_d   = i_Rx_Byte;
                        state_d = S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (i_Rx_Error) begin
                        drop = 1'b1;
                    end else begin
                        addr_d  = i_Rx_Byte;
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    if (i_Rx_Error) begin
                        drop = 1'b1;
                    end else begin
                        data_d  = i_Rx_Byte;
                        state_d = S_CHK;
                    end
                end
                S_CHK: begin
                    state_d = S_IDLE;
                    if (i_Rx_Error || (i_Rx_Byte != (cmd_q ^ addr_q ^ data_q))) begin
                        drop = 1'b1;
                    end else if (cmd_q == CMD_WR) begin
                        wr_en_d     = 1'b1;
                        out_addr_d  = addr_q;
                        out_wdata_d = data_q;
                    end else if (cmd_q == CMD_RD) begin
                        rd_en_d    = 1'b1;
                        out_addr_d = addr_q;
                    end else begin
                        drop = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (timeout) begin
            drop = 1'b1;
        end

        if (drop) begin
            state_d = S_IDLE;
            ferr_d  = 1'b1;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q     <= S_IDLE;
            dv_q        <= 1'b0;
            timer_q     <= '0;
            cmd_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            ferr_q      <= 1'b0;
            out_addr_q  <= '0;
            out_wdata_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            dv_q        <= i_Rx_DV;
            timer_q     <= timer_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            ferr_q      <= ferr_d;
            out_addr_q  <= out_addr_d;
            out_wdata_q <= out_wdata_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign o_Wr_En     = wr_en_q;
    assign o_Rd_En     = rd_en_q;
    assign o_Addr      = out_addr_q;
    assign o_Wr_Data   = out_wdata_q;
    assign o_Busy      = (state_q != S_IDLE);
    assign o_Frame_Err = ferr_q;
    assign o_Err_Count = err_cnt_q;

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// Scoreboard bench for uart_rx_cmd_ctrl: stimulus pushes expected strobe/error events,
// a negedge monitor pops and compares them whenever the DUT raises a strobe or error pulse.
module tb_uart_rx_cmd_ctrl;

    localparam int K_WR  = 0;
    localparam int K_RD  = 1;
    localparam int K_ERR = 2;

    logic       clk;
    logic       rst_n;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       rx_err;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       ferr;
    logic [7:0] ecnt;

    uart_rx_cmd_ctrl #(
        .TIMEOUT_CLKS(50),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .i_Clock    (clk),
        .i_Rst_n    (rst_n),
        .i_Rx_DV    (rx_dv),
        .i_Rx_Byte  (rx_byte),
        .i_Rx_Error (rx_err),
        .o_Wr_En    (wr_en),
        .o_Rd_En    (rd_en),
        .o_Addr     (addr),
        .o_Wr_Data  (wdata),
        .o_Busy     (busy),
        .o_Frame_Err(ferr),
        .o_Err_Count(ecnt)
    );

    typedef struct {
        int         kind;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] ecnt;
        int         cyc;
    } exp_t;

    exp_t q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] m_addr  = 8'h00;
    logic [7:0] m_wdata = 8'h00;
    logic [7:0] m_ecnt  = 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Model update + expected-event push; kind is chosen by hand per vector.
    task automatic push_exp(input int kind, input logic [7:0] a, input logic [7:0] d, input int at_cyc);
        exp_t e;
        if (kind == K_WR) begin
            m_addr  = a;
            m_wdata = d;
        end else if (kind == K_RD) begin
            m_addr = a;
        end else if (m_ecnt != 8'hFF) begin
            m_ecnt = m_ecnt + 8'd1;
        end
        e.kind  = kind;
        e.addr  = m_addr;
        e.wdata = m_wdata;
        e.ecnt  = m_ecnt;
        e.cyc   = at_cyc;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && (wr_en || rd_en || ferr)) begin
            exp_t e;
            int   got;
            got = ferr ? K_ERR : (wr_en ? K_WR : K_RD);
            check("excl_strobes", {29'd0, wr_en, rd_en, ferr} & ((wr_en & rd_en) | (ferr & (wr_en | rd_en)) ? 32'h7 : 32'h0), 32'h0);
            if (q.size() == 0) begin
                check("unexpected_event", got, 32'hFFFF);
            end else begin
                e = q.pop_front();
                check("event_kind", got, e.kind);
                check("event_addr", addr, e.addr);
                check("event_wdata", wdata, e.wdata);
                check("event_ecnt", ecnt, e.ecnt);
                check("event_busy_low", busy, 1'b0);
                if (e.cyc >= 0) check("event_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic raise(input logic [7:0] b, input logic err, output int acc);
        @(negedge clk);
        rx_dv   = 1'b1;
        rx_byte = b;
        rx_err  = err;
        @(posedge clk);
        #1 acc = cyc;
    endtask

    task automatic lower(input int hold);
        repeat (hold - 1) @(posedge clk);
        @(negedge clk);
        rx_dv  = 1'b0;
        rx_err = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic err, input int hold, output int acc);
        raise(b, err, acc);
        lower(hold);
    endtask

    // Sync then cmd/addr/data/chk; stops after the byte at errpos (flagged with parity error).
    task automatic frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d, input logic [7:0] k,
                         input int errpos, input int hold, input int kind, input bit check_busy);
        logic [7:0] b[4];
        int acc;
        b[0] = c; b[1] = a; b[2] = d; b[3] = k;
        send_byte(8'hA5, 1'b0, hold, acc);
        if (check_busy) check("busy_after_sync", busy, 1'b1);
        for (int i = 0; i < 4; i++) begin
            raise(b[i], (i == errpos), acc);
            if (i == errpos || i == 3) begin
                push_exp(kind, a, d, acc);
                lower(hold);
                break;
            end
            lower(hold);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check({name, "_pending"}, q.size(), 0);
        check({name, "_busy"}, busy, 1'b0);
        check({name, "_ecnt"}, ecnt, m_ecnt);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, pending=%0d", q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int a1;
        rst_n   = 1'b0;
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
        rx_err  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_rd_en", rd_en, 1'b0);
        check("rst_addr", addr, 8'h00);
        check("rst_wdata", wdata, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_ferr", ferr, 1'b0);
        check("rst_ecnt", ecnt, 8'h00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        frame(8'h01, 8'h10, 8'h3C, 8'h2D, -1, 3, K_WR, 1'b1);
        drain("write");
        frame(8'h02, 8'h20, 8'h00, 8'h22, -1, 3, K_RD, 1'b1);
        drain("read");
        frame(8'h01, 8'h10, 8'h3C, 8'h2E, -1, 2, K_ERR, 1'b0);
        drain("badchk");
        frame(8'h01, 8'h10, 8'h3C, 8'h2D, 1, 2, K_ERR, 1'b0);
        drain("parity_addr");
        frame(8'h01, 8'h44, 8'h55, 8'h10, -1, 2, K_WR, 1'b0);
        drain("write_after_err");
        send_byte(8'h5A, 1'b1, 2, a0);
        drain("idle_noise");
        frame(8'h03, 8'h10, 8'h20, 8'h33, -1, 1, K_ERR, 1'b0);
        drain("bad_cmd");
        frame(8'h01, 8'hA5, 8'hA5, 8'h01, -1, 1, K_WR, 1'b0);
        drain("sync_as_data");

        // Timeout: error pulse seen 51 edges after the edge accepting the 01 byte.
        send_byte(8'hA5, 1'b0, 1, a0);
        raise(8'h01, 1'b0, a1);
        push_exp(K_ERR, 8'h00, 8'h00, a1 + 51);
        lower(1);
        repeat (60) @(negedge clk);
        drain("timeout");

        // Byte landing on the expiry cycle is accepted and the frame completes.
        send_byte(8'hA5, 1'b0, 1, a0);
        send_byte(8'h01, 1'b0, 1, a1);
        repeat (49) @(negedge clk);
        send_byte(8'h10, 1'b0, 1, a0);
        check("expiry_accept_cycle_gap", a0 - a1, 51);
        repeat (3) @(negedge clk);
        check("expiry_busy", busy, 1'b1);
        check("expiry_ecnt", ecnt, m_ecnt);
        send_byte(8'h3C, 1'b0, 1, a0);
        raise(8'h2D, 1'b0, a0);
        push_exp(K_WR, 8'h10, 8'h3C, a0);
        lower(1);
        drain("expiry_write");

        // Asynchronous reset in the middle of a frame.
        send_byte(8'hA5, 1'b0, 1, a0);
        send_byte(8'h01, 1'b0, 1, a0);
        send_byte(8'h10, 1'b0, 1, a0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_wr_en", wr_en, 1'b0);
        check("midrst_rd_en", rd_en, 1'b0);
        check("midrst_addr", addr, 8'h00);
        check("midrst_wdata", wdata, 8'h00);
        check("midrst_busy", busy, 1'b0);
        check("midrst_ferr", ferr, 1'b0);
        check("midrst_ecnt", ecnt, 8'h00);
        m_addr  = 8'h00;
        m_wdata = 8'h00;
        m_ecnt  = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'h3C, 1'b0, 1, a0);
        send_byte(8'h2D, 1'b0, 1, a0);
        drain("after_reset");

        for (int i = 0; i < 256; i++) begin
            frame(8'h01, 8'h10, 8'h3C, 8'h2E, -1, 1, K_ERR, 1'b0);
        end
        drain("saturate");
        check("saturate_ff", ecnt, 8'hFF);
        frame(8'h02, 8'h77, 8'h00, 8'h75, -1, 1, K_RD, 1'b0);
        drain("read_after_sat");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
